// File: rtl/instr_fetch_unit.sv
// MIPS multicycle fetch stage: owns PC and IR, handshakes with instruction memory, computes next PC.
// Latency: IR valid 1+N cycles after entering FETCH (N = memory wait cycles); PC updates on the pc_wr edge in HOLD.
// Backpressure: stays in FETCH with imem_req high until imem_ack; waits in HOLD until control raises pc_wr.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_wr,
    input  logic [1:0]  npc_sel,
    input  logic        br_take,
    input  logic [15:0] imm16,
    input  logic [25:0] jadd,
    input  logic [31:0] rs_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] npc;
    logic        fetch_done;
    logic        advance;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign fetch_done = (state_q == FETCH) && imem_ack;
    assign advance    = (state_q == HOLD) && pc_wr;

    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            2'b00: npc = pc_plus4;
            2'b01: npc = br_take ? (pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}) : pc_plus4;
            2'b10: npc = {pc_plus4[31:28], jadd, 2'b00};
            2'b11: npc = {rs_val[31:2], 2'b00};
            default: npc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (pc_wr) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IR is written only on the ack edge, so it stays frozen for the whole execute phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir_out   <= 32'd0;
            ir_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            misalign <= advance && (npc_sel == 2'b11) && (rs_val[1:0] != 2'b00);
            if (fetch_done) begin
                ir_out   <= imem_rdata;
                ir_valid <= 1'b1;
            end else if (advance) begin
                pc       <= npc;
                ir_valid <= 1'b0;
            end
        end
    end

endmodule
